onchip_mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the 2048x16 single-port on-chip RAM between two Avalon-MM requesters (m0, m1).
- Registers ownership, limits consecutive accesses per owner, and drives the RAM slave port.
- Returns read data with a readdatavalid pulse, matching the RAM's one-cycle read latency (registered address, unregistered q).

---
 rtl/onchip_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip RAM between two Avalon-MM requesters.
// Ownership is registered; the owner's request drives the RAM combinationally and reads return one cycle later.
module onchip_mem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               last_owner, last_nx;
    logic [1:0]         req, rd_only, xfer, rd_pend;
    logic               own;
    logic [ADDR_W-1:0]  addr_q;
    logic [BE_W-1:0]    be_q;
    logic [DATA_W-1:0]  wd_q;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    // read+write together counts as a write, so it never produces a read return
    assign rd_only = {m1_read & ~m1_write, m0_read & ~m0_write};
    assign own     = (state == OWN1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last_owner;
        xfer     = '0;
        case (state)
            IDLE: begin
                if (req[0] && (!req[1] || last_owner)) begin
                    state_nx = OWN0;
                    cnt_nx   = '0;
                end else if (req[1]) begin
                    state_nx = OWN1;
                    cnt_nx   = '0;
                end
            end
            OWN0, OWN1: begin
                xfer[own] = req[own];
                if (req[own]) begin
                    last_nx = own;
                    if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
                end
                // hand over directly (no bubble) when the other side waits and we are done or idle
                if (req[~own] && (!req[own] || cnt == CNT_MAX)) begin
                    state_nx = own ? OWN0 : OWN1;
                    cnt_nx   = '0;
                end else if (!req[own]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_address    = addr_q;
        mem_byteenable = be_q;
        mem_writedata  = wd_q;
        mem_write      = 1'b0;
        if (xfer[0]) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (xfer[1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end
    end

    assign mem_chipselect   = |xfer;
    assign m0_waitrequest   = ~xfer[0];
    assign m1_waitrequest   = ~xfer[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend[0];
    assign m1_readdatavalid = rd_pend[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            rd_pend    <= '0;
            mem_clken  <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wd_q       <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_owner <= last_nx;
            rd_pend    <= xfer & rd_only;
            mem_clken  <= 1'b1;
            if (|xfer) begin
                addr_q <= mem_address;
                be_q   <= mem_byteenable;
                wd_q   <= mem_writedata;
            end
        end
    end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: RAM model with 1-cycle read latency, shadow memory
// for expected read data, and per-cycle checks of grant exclusivity and read-return routing.
module tb_onchip_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] m0_address = '0, m1_address = '0;
    logic [1:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [15:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [15:0] m0_readdata, m1_readdata;
    logic [10:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.MAX_BURST(4), .ADDR_W(11), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    function automatic logic [15:0] pat(input logic [10:0] a);
        return {5'h00, a} ^ 16'h5A5A;
    endfunction

    // RAM model: registered address, unregistered q
    logic [15:0] ram [0:2047];
    logic [10:0] ram_a;
    logic        preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 2048; i++) ram[i] <= pat(11'(i));
            preloaded <= 1'b1;
        end else if (mem_clken && mem_chipselect) begin
            ram_a <= mem_address;
            if (mem_write) begin
                if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
                if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
            end
        end
    end
    assign mem_readdata = ram[ram_a];

    int          n_chk = 0, n_fail = 0;
    int          gnt = 2;
    logic [1:0]  pv = '0;
    logic [15:0] pd = '0;
    logic        obs_v0, obs_v1;
    logic [15:0] obs_d0, obs_d1;
    logic [15:0] shd [0:2047];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at each negedge: checks read returns owed from last cycle, then records this cycle's grant.
    task automatic sample();
        logic [1:0] w;
        chk("rdv0", m0_readdatavalid, pv[0]);
        chk("rdv1", m1_readdatavalid, pv[1]);
        if (pv[0]) chk("rdata0", m0_readdata, pd);
        if (pv[1]) chk("rdata1", m1_readdata, pd);
        obs_v0 = m0_readdatavalid; obs_d0 = m0_readdata;
        obs_v1 = m1_readdatavalid; obs_d1 = m1_readdata;
        w = {m1_waitrequest, m0_waitrequest};
        chk("excl", (w == 2'b00), 1'b0);
        gnt = !w[0] ? 0 : (!w[1] ? 1 : 2);
        pv = '0;
        if (gnt == 0) begin
            if (m0_write) begin
                if (m0_byteenable[0]) shd[m0_address][7:0]  = m0_writedata[7:0];
                if (m0_byteenable[1]) shd[m0_address][15:8] = m0_writedata[15:8];
            end else if (m0_read) begin
                pv[0] = 1'b1; pd = shd[m0_address];
            end
        end else if (gnt == 1) begin
            if (m1_write) begin
                if (m1_byteenable[0]) shd[m1_address][7:0]  = m1_writedata[7:0];
                if (m1_byteenable[1]) shd[m1_address][15:8] = m1_writedata[15:8];
            end else if (m1_read) begin
                pv[1] = 1'b1; pd = shd[m1_address];
            end
        end
    endtask

    task automatic release_all();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    task automatic idle(input int n);
        release_all();
        repeat (n) begin
            @(negedge clk); sample();
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pv = '0;
        release_all();
        repeat (2) begin
            @(negedge clk); sample();
            chk("rst_w0", m0_waitrequest, 1'b1);
            chk("rst_w1", m1_waitrequest, 1'b1);
            chk("rst_cs", mem_chipselect, 1'b0);
            chk("rst_mwr", mem_write, 1'b0);
            chk("rst_clken", mem_clken, 1'b0);
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
    endtask

    // Issue one transfer from master s; returns one edge after acceptance with request still driven.
    task automatic m_op(input int s, input logic rd, input logic wr, input logic [10:0] a,
                        input logic [1:0] be, input logic [15:0] wd, output int waits);
        if (s == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
        end
        waits = 0;
        while (1) begin
            @(negedge clk); sample();
            if (gnt == s || waits >= 20) break;
            waits++;
            @(posedge clk); #1;
        end
        chk("op_gnt", gnt, s);
        chk("op_mwr", mem_write, wr);
        chk("op_maddr", mem_address, a);
        chk("op_mbe", mem_byteenable, be);
        if (wr) chk("op_mwd", mem_writedata, wd);
        @(posedge clk); #1;
    endtask

    // Continuous reads from the enabled masters until n transfers are accepted.
    task automatic run_stream(input logic en0, input logic en1, input int n,
                              input logic [10:0] b0, input logic [10:0] b1,
                              output int first, output int gaps, output logic [31:0] seq);
        int acc, cyc;
        acc = 0; cyc = 0; first = -1; gaps = 0; seq = '0;
        m0_write = 1'b0; m1_write = 1'b0; m0_byteenable = 2'b11; m1_byteenable = 2'b11;
        m0_address = b0; m1_address = b1; m0_read = en0; m1_read = en1;
        while (acc < n && cyc < 60) begin
            @(negedge clk); sample();
            if (gnt < 2) begin
                if (first < 0) first = cyc;
                seq[acc] = gnt[0];
                acc++;
            end else if (first >= 0) begin
                gaps++;
            end
            @(posedge clk); #1;
            if (gnt == 0) m0_address = m0_address + 11'd1;
            if (gnt == 1) m1_address = m1_address + 11'd1;
            if (acc >= n) release_all();
            cyc++;
        end
    endtask

    initial begin
        int w, first, gaps;
        logic [31:0] seq;
        for (int i = 0; i < 2048; i++) shd[i] = pat(11'(i));

        do_reset();
        idle(2);
        chk("clken_on", mem_clken, 1'b1);

        // write then back-to-back read
        m_op(0, 1'b0, 1'b1, 11'h005, 2'b11, 16'hBEEF, w);
        chk("t1_idle_grant", w, 1);
        m_op(0, 1'b1, 1'b0, 11'h005, 2'b11, 16'h0000, w);
        chk("t1_b2b", w, 0);
        idle(1);
        chk("t1_rdv", obs_v0, 1'b1);
        chk("t1_data", obs_d0, 16'hBEEF);
        idle(2);
        chk("hold_addr", mem_address, 11'h005);
        chk("hold_cs", mem_chipselect, 1'b0);

        // byte lanes at top address
        m_op(0, 1'b0, 1'b1, 11'h7FF, 2'b11, 16'h1234, w);
        m_op(0, 1'b0, 1'b1, 11'h7FF, 2'b10, 16'hAB00, w);
        m_op(0, 1'b1, 1'b0, 11'h7FF, 2'b11, 16'h0000, w);
        idle(1);
        chk("be_rdv", obs_v0, 1'b1);
        chk("be_data", obs_d0, 16'hAB34);

        // read+write together acts as a write
        m_op(0, 1'b1, 1'b1, 11'h010, 2'b11, 16'h00FF, w);
        idle(1);
        chk("rw_no_rdv", obs_v0, 1'b0);
        m_op(0, 1'b1, 1'b0, 11'h010, 2'b11, 16'h0000, w);
        idle(1);
        chk("rw_data", obs_d0, 16'h00FF);

        // m1 data path
        m_op(1, 1'b0, 1'b1, 11'h400, 2'b11, 16'hC3C3, w);
        m_op(1, 1'b1, 1'b0, 11'h400, 2'b11, 16'h0000, w);
        idle(1);
        chk("m1_rdv", obs_v1, 1'b1);
        chk("m1_data", obs_d1, 16'hC3C3);
        idle(2);

        // contention from reset: 4/4 alternation, no bubbles
        do_reset();
        run_stream(1'b1, 1'b1, 16, 11'h200, 11'h300, first, gaps, seq);
        idle(1);
        chk("rr_first", first, 1);
        chk("rr_gaps", gaps, 0);
        chk("rr_seq", seq, 32'h0000F0F0);
        idle(2);

        // single requester is never forced to yield
        run_stream(1'b0, 1'b1, 10, 11'h000, 11'h100, first, gaps, seq);
        idle(1);
        chk("solo_first", first, 1);
        chk("solo_gaps", gaps, 0);
        chk("solo_seq", seq, 32'h000003FF);
        idle(2);

        // reset right after an accepted read drops the return and restores m0-first tie
        m_op(0, 1'b1, 1'b0, 11'h020, 2'b11, 16'h0000, w);
        do_reset();
        run_stream(1'b1, 1'b1, 1, 11'h030, 11'h040, first, gaps, seq);
        idle(1);
        chk("rst_tie_first", first, 1);
        chk("rst_tie_owner", seq[0], 1'b0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
